// File: rtl/sram_pkg.sv
// Shared types and constants for the external asynchronous SRAM controller.
package sram_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD
    } state_t;

    localparam int READ_LATENCY_DEF = 2;

    // Pin bundle order is {CE, OE, WE, LB, UB}, all active-low.
    localparam logic [4:0] CTRL_IDLE = 5'b11111;
    localparam logic [4:0] CTRL_READ = 5'b00100;

endpackage

// File: rtl/sram_dq_buf.sv
// Tri-state pad for the bidirectional SRAM data bus, keeping the inout out of the FSM.
module sram_dq_buf #(
    parameter int DATA_W = 16
) (
    input  logic              oe,
    input  logic [DATA_W-1:0] dout,
    output logic [DATA_W-1:0] din,
    inout  wire  [DATA_W-1:0] pad
);

    assign pad = oe ? dout : {DATA_W{1'bz}};
    assign din = pad;

endmodule

// File: rtl/sram_ctrl.sv
// CPU-side controller for an asynchronous 256Kx16 SRAM: one FSM sequences the
// registered active-low pins for single-word reads and byte-enabled writes.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int READ_LATENCY = READ_LATENCY_DEF,
    parameter int ADDR_W       = 18,
    parameter int DATA_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_be,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              SRAM_CE,
    output logic              SRAM_OE,
    output logic              SRAM_WE,
    output logic              SRAM_LB,
    output logic              SRAM_UB,
    output logic [ADDR_W-1:0] SRAM_A,
    inout  wire  [DATA_W-1:0] SRAM_D
);

    localparam int CNT_W = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);

    state_t            state;
    logic [4:0]        ctrl;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] wdata;
    logic              drive;
    logic [DATA_W-1:0] din;

    assign {SRAM_CE, SRAM_OE, SRAM_WE, SRAM_LB, SRAM_UB} = ctrl;
    assign req_ready = (state == S_IDLE);

    sram_dq_buf #(.DATA_W(DATA_W)) u_dq (
        .oe   (drive),
        .dout (wdata),
        .din  (din),
        .pad  (SRAM_D)
    );

    // Async reset releases the bus and raises every control at once, so an
    // interrupted write can never complete its pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ctrl      <= CTRL_IDLE;
            cnt       <= '0;
            wdata     <= '0;
            drive     <= 1'b0;
            SRAM_A    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        SRAM_A <= req_addr;
                        if (req_we) begin
                            wdata <= req_wdata;
                            drive <= 1'b1;
                            ctrl  <= {1'b0, 1'b1, 1'b1, ~req_be[0], ~req_be[1]};
                            state <= S_WR_SETUP;
                        end else begin
                            ctrl  <= CTRL_READ;
                            cnt   <= CNT_W'(READ_LATENCY);
                            state <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (cnt == '0) begin
                        rsp_rdata <= din;
                        rsp_valid <= 1'b1;
                        ctrl      <= CTRL_IDLE;
                        state     <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_WR_SETUP: begin
                    ctrl[2] <= 1'b0;
                    state   <= S_WR_PULSE;
                end
                S_WR_PULSE: begin
                    ctrl[2] <= 1'b1;
                    state   <= S_WR_HOLD;
                end
                S_WR_HOLD: begin
                    ctrl  <= CTRL_IDLE;
                    drive <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    ctrl  <= CTRL_IDLE;
                    drive <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: a 2-cycle-latency SRAM device model on the pins
// plus a word-array reference memory that tracks what every read must return.
module tb_sram_ctrl;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;
    localparam int LAT    = 2;
    localparam int WORDS  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic [1:0]        req_be = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              SRAM_CE, SRAM_OE, SRAM_WE, SRAM_LB, SRAM_UB;
    logic [ADDR_W-1:0] SRAM_A;
    tri1  [DATA_W-1:0] SRAM_D;

    int n_tests = 0;
    int n_fail  = 0;
    int bus_err = 0;
    int cyc     = 0;

    sram_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .SRAM_CE   (SRAM_CE),
        .SRAM_OE   (SRAM_OE),
        .SRAM_WE   (SRAM_WE),
        .SRAM_LB   (SRAM_LB),
        .SRAM_UB   (SRAM_UB),
        .SRAM_A    (SRAM_A),
        .SRAM_D    (SRAM_D)
    );

    always #5 clk = ~clk;
    always @(negedge clk) cyc <= cyc + 1;

    // SRAM device model: writes land on the edge that ends a WE-low cycle, read
    // data appears once OE/CE have been low for LAT edges. Undriven bus reads all ones.
    logic [DATA_W-1:0] sram_mem [0:WORDS-1];
    logic [DATA_W-1:0] ref_mem  [0:WORDS-1];
    logic              pre_en = 1'b0;
    logic [ADDR_W-1:0] pre_addr = '0;
    logic [DATA_W-1:0] pre_data = '0;
    int                rd_cnt = 0;

    always @(posedge clk) begin
        if (pre_en) sram_mem[pre_addr] <= pre_data;
        if (!SRAM_CE && !SRAM_WE) begin
            if (!SRAM_LB) sram_mem[SRAM_A][7:0]  <= SRAM_D[7:0];
            if (!SRAM_UB) sram_mem[SRAM_A][15:8] <= SRAM_D[15:8];
        end
        rd_cnt <= (!SRAM_CE && !SRAM_OE) ? rd_cnt + 1 : 0;
    end

    assign SRAM_D = (!SRAM_CE && !SRAM_OE && rd_cnt >= LAT) ? sram_mem[SRAM_A] : {DATA_W{1'bz}};

    int                acc_q[$];
    int                rsp_cyc_q[$];
    logic [DATA_W-1:0] rsp_dat_q[$];

    always @(posedge clk) if (rst_n && req_valid && req_ready) acc_q.push_back(cyc);

    always @(posedge clk) begin
        #1;
        if (rsp_valid) begin
            rsp_cyc_q.push_back(cyc);
            rsp_dat_q.push_back(rsp_rdata);
        end
    end

    // Bus integrity: OE and WE never low together, no unknowns, and while a read
    // is open the bus shows either nothing or the device's own data.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!SRAM_OE && !SRAM_WE) bus_err <= bus_err + 1;
            if ($isunknown(SRAM_D)) bus_err <= bus_err + 1;
            if (!SRAM_CE && !SRAM_OE && SRAM_D !== 16'hFFFF && SRAM_D !== sram_mem[SRAM_A])
                bus_err <= bus_err + 1;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_en = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic drive_req(input logic we, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d, input logic [1:0] be,
                             output int acc_at);
        int n;
        n = acc_q.size();
        acc_at = -1;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
        for (int i = 0; i < 20 && acc_at < 0; i++) begin
            @(posedge clk); #1;
            if (acc_q.size() > n) acc_at = acc_q[n];
        end
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = ADDR_W'($urandom);
        req_wdata = DATA_W'($urandom);
        req_be    = 2'($urandom);
        n_tests++;
        if (acc_at < 0) begin
            n_fail++;
            $display("[TB] FAIL accept_timeout: addr %h not accepted within 20 cycles", a);
        end
    endtask

    task automatic read_word(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] data,
                             output int lat, output int oe_low, output int pulses);
        int acc, r0;
        r0 = rsp_cyc_q.size();
        drive_req(1'b0, a, '0, 2'b00, acc);
        oe_low = 0;
        repeat (6) begin
            @(negedge clk);
            if (!SRAM_OE && !SRAM_CE) oe_low++;
        end
        pulses = rsp_cyc_q.size() - r0;
        if (pulses > 0) begin
            data = rsp_dat_q[r0];
            lat  = rsp_cyc_q[r0] - acc;
        end else begin
            data = '0;
            lat  = -1;
        end
    endtask

    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                              input logic [1:0] be, output int we_low, output int bad);
        int acc;
        drive_req(1'b1, a, d, be, acc);
        we_low = 0;
        bad    = 0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (!SRAM_WE) we_low++;
            if (j < 3) begin
                if (SRAM_CE !== 1'b0 || SRAM_OE !== 1'b1 || SRAM_A !== a || SRAM_D !== d) bad++;
                if (SRAM_LB !== ~be[0] || SRAM_UB !== ~be[1]) bad++;
                if (SRAM_WE !== (j != 1)) bad++;
            end else begin
                if (SRAM_CE !== 1'b1 || SRAM_WE !== 1'b1 || SRAM_D !== 16'hFFFF) bad++;
            end
        end
        if (be[0]) ref_mem[a][7:0]  = d[7:0];
        if (be[1]) ref_mem[a][15:8] = d[15:8];
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({SRAM_CE, SRAM_OE, SRAM_WE, SRAM_LB, SRAM_UB, req_ready, rsp_valid} !== 7'b1111110) begin
            n_fail++;
            $display("[TB] FAIL reset_pins: got %b, expected 1111110",
                     {SRAM_CE, SRAM_OE, SRAM_WE, SRAM_LB, SRAM_UB, req_ready, rsp_valid});
        end
        n_tests++;
        if (SRAM_A !== '0 || rsp_rdata !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_regs: addr %h rdata %h, expected 0 and 0", SRAM_A, rsp_rdata);
        end
        n_tests++;
        if (SRAM_D !== 16'hFFFF) begin
            n_fail++;
            $display("[TB] FAIL reset_bus: got %h, expected released bus FFFF", SRAM_D);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_read;
        logic [DATA_W-1:0] d;
        int lat, oe_low, pulses;
        preload(18'h00005, 16'hBEEF);
        read_word(18'h00005, d, lat, oe_low, pulses);
        n_tests++;
        if (d !== 16'hBEEF) begin
            n_fail++; $display("[TB] FAIL read_data: got %h, expected BEEF", d);
        end
        n_tests++;
        if (lat != LAT + 1) begin
            n_fail++; $display("[TB] FAIL read_latency: got %0d, expected %0d", lat, LAT + 1);
        end
        n_tests++;
        if (oe_low != LAT + 1) begin
            n_fail++; $display("[TB] FAIL read_oe_cycles: got %0d, expected %0d", oe_low, LAT + 1);
        end
        n_tests++;
        if (pulses != 1) begin
            n_fail++; $display("[TB] FAIL read_pulses: got %0d, expected 1", pulses);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (rsp_rdata !== 16'hBEEF || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL read_hold: rdata %h valid %b, expected BEEF and 0", rsp_rdata, rsp_valid);
        end
    endtask

    task automatic test_reset_mid;
        int acc, r0;
        logic [DATA_W-1:0] d;
        int lat, oe_low, pulses;
        preload(18'h002AB, 16'h1357);
        r0 = rsp_cyc_q.size();
        drive_req(1'b0, 18'h002AB, '0, 2'b00, acc);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({SRAM_CE, SRAM_OE, SRAM_WE, SRAM_LB, SRAM_UB, req_ready} !== 6'b111111 || SRAM_A !== '0) begin
            n_fail++;
            $display("[TB] FAIL midreset_pins: ctrl %b addr %h, expected 111111 and 0",
                     {SRAM_CE, SRAM_OE, SRAM_WE, SRAM_LB, SRAM_UB, req_ready}, SRAM_A);
        end
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        n_tests++;
        if (rsp_cyc_q.size() != r0) begin
            n_fail++;
            $display("[TB] FAIL midreset_rsp: got %0d responses, expected 0", rsp_cyc_q.size() - r0);
        end
        read_word(18'h002AB, d, lat, oe_low, pulses);
        n_tests++;
        if (d !== 16'h1357) begin
            n_fail++; $display("[TB] FAIL midreset_reread: got %h, expected 1357", d);
        end
    endtask

    task automatic test_write_read;
        logic [DATA_W-1:0] d;
        int lat, oe_low, pulses, we_low, bad;
        write_word(18'h001A5, 16'h1234, 2'b11, we_low, bad);
        n_tests++;
        if (we_low != 1) begin
            n_fail++; $display("[TB] FAIL write_we_cycles: got %0d, expected 1", we_low);
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("[TB] FAIL write_pin_sequence: got %0d bad samples, expected 0", bad);
        end
        read_word(18'h001A5, d, lat, oe_low, pulses);
        n_tests++;
        if (d !== 16'h1234) begin
            n_fail++; $display("[TB] FAIL write_readback: got %h, expected 1234", d);
        end
    endtask

    task automatic test_byte_writes;
        logic [1:0]        be_tab  [3] = '{2'b01, 2'b10, 2'b00};
        logic [DATA_W-1:0] exp_tab [3] = '{16'hAA55, 16'h55AA, 16'hAAAA};
        logic [DATA_W-1:0] d;
        int lat, oe_low, pulses, we_low, bad;
        for (int i = 0; i < 3; i++) begin
            preload(18'h000C0, 16'hAAAA);
            write_word(18'h000C0, 16'h5555, be_tab[i], we_low, bad);
            read_word(18'h000C0, d, lat, oe_low, pulses);
            n_tests++;
            if (d !== exp_tab[i] || bad != 0 || we_low != 1) begin
                n_fail++;
                $display("[TB] FAIL byte_write be=%b: got %h (bad %0d, we_low %0d), expected %h",
                         be_tab[i], d, bad, we_low, exp_tab[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [ADDR_W-1:0] pool [6];
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        int lat, oe_low, pulses, we_low, bad;
        for (int i = 0; i < 6; i++) begin
            pool[i] = ADDR_W'($urandom);
            preload(pool[i], DATA_W'($urandom));
        end
        for (int i = 0; i < 24; i++) begin
            a = pool[$urandom_range(0, 5)];
            if ($urandom_range(0, 1) == 1) begin
                write_word(a, DATA_W'($urandom), 2'($urandom), we_low, bad);
                n_tests++;
                if (bad != 0 || we_low != 1) begin
                    n_fail++;
                    $display("[TB] FAIL rand_write %h: bad %0d we_low %0d, expected 0 and 1", a, bad, we_low);
                end
            end else begin
                read_word(a, d, lat, oe_low, pulses);
                n_tests++;
                if (d !== ref_mem[a] || lat != LAT + 1) begin
                    n_fail++;
                    $display("[TB] FAIL rand_read %h: got %h lat %0d, expected %h lat %0d",
                             a, d, lat, ref_mem[a], LAT + 1);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [ADDR_W-1:0] addrs [3];
        int a0, r0, k;
        for (int i = 0; i < 3; i++) begin
            addrs[i] = ADDR_W'(18'h10000 + i * 7);
            preload(addrs[i], DATA_W'($urandom));
        end
        a0 = acc_q.size();
        r0 = rsp_cyc_q.size();
        k  = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = addrs[0];
        for (int c = 0; c < 40 && k < 3; c++) begin
            @(posedge clk); #1;
            if (acc_q.size() > a0 + k) begin
                k++;
                if (k < 3) req_addr = addrs[k];
            end
        end
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        n_tests++;
        if (k != 3) begin
            n_fail++; $display("[TB] FAIL b2b_accepts: got %0d, expected 3", k);
        end else begin
            n_tests++;
            if (acc_q[a0 + 1] - acc_q[a0] != 4 || acc_q[a0 + 2] - acc_q[a0 + 1] != 4) begin
                n_fail++;
                $display("[TB] FAIL b2b_spacing: got %0d and %0d, expected 4 and 4",
                         acc_q[a0 + 1] - acc_q[a0], acc_q[a0 + 2] - acc_q[a0 + 1]);
            end
        end
        n_tests++;
        if (rsp_cyc_q.size() - r0 != 3) begin
            n_fail++; $display("[TB] FAIL b2b_responses: got %0d, expected 3", rsp_cyc_q.size() - r0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (rsp_dat_q[r0 + i] !== ref_mem[addrs[i]]) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_data[%0d]: got %h, expected %h", i, rsp_dat_q[r0 + i], ref_mem[addrs[i]]);
                end
            end
        end
    endtask

    task automatic test_reset_in_write;
        int acc, r0;
        logic [DATA_W-1:0] d;
        int lat, oe_low, pulses;
        preload(18'h003C3, 16'h0F0F);
        r0 = rsp_cyc_q.size();
        drive_req(1'b1, 18'h003C3, 16'h7E7E, 2'b11, acc);
        @(posedge clk); #1;
        n_tests++;
        if (SRAM_WE !== 1'b0) begin
            n_fail++; $display("[TB] FAIL wrreset_pulse_seen: WE %b, expected 0", SRAM_WE);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (SRAM_WE !== 1'b1 || SRAM_CE !== 1'b1 || SRAM_D !== 16'hFFFF) begin
            n_fail++;
            $display("[TB] FAIL wrreset_async: WE %b CE %b bus %h, expected 1 1 FFFF", SRAM_WE, SRAM_CE, SRAM_D);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n_tests++;
        if (rsp_cyc_q.size() != r0 || SRAM_WE !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL wrreset_quiet: responses %0d WE %b, expected 0 and 1",
                     rsp_cyc_q.size() - r0, SRAM_WE);
        end
        read_word(18'h003C3, d, lat, oe_low, pulses);
        n_tests++;
        if ($isunknown(d) || (d !== 16'h0F0F && d !== 16'h7E7E)) begin
            n_fail++; $display("[TB] FAIL wrreset_reread: got %h, expected 0F0F or 7E7E", d);
        end
    endtask

    task automatic test_bus_integrity;
        n_tests++;
        if (bus_err != 0) begin
            n_fail++; $display("[TB] FAIL bus_integrity: got %0d violations, expected 0", bus_err);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_reset_mid();
        test_write_read();
        test_byte_writes();
        test_random();
        test_back_to_back();
        test_reset_in_write();
        test_bus_integrity();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

CPU-side initiator for the external asynchronous 256K×16 SRAM; the counterpart of the bench SRAM responder model. Accepts single-word read/write requests from the CPU over a valid/ready handshake and sequences the active-low SRAM pins (`SRAM_CE`, `SRAM_OE`, `SRAM_WE`, `SRAM_LB`, `SRAM_UB`), the address bus and the bidirectional data bus. Read data returns on a one-cycle response strobe. Sits between `cpu2` and the board/harness SRAM pins.

## Interface
- `READ_LATENCY`, 2: number of clock edges from the first edge at which `SRAM_A` is presented to the edge at which `SRAM_D` holds valid read data.
- `ADDR_W`, 18: SRAM word-address width.
- `DATA_W`, 16: SRAM data width.
- `clk` input 1: sole clock, all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: controller idle, request accepted on `req_valid && req_ready`.
- `req_we` input 1: 1 = write, 0 = read.
- `req_addr` input ADDR_W: word address.
- `req_wdata` input DATA_W: write data.
- `req_be` input 2: byte enables, bit0 = low byte, bit1 = high byte (writes only).
- `rsp_valid` output 1: one-cycle pulse, read data valid.
- `rsp_rdata` output DATA_W: read data, held until next read response.
- `SRAM_CE`, `SRAM_OE`, `SRAM_WE`, `SRAM_LB`, `SRAM_UB` output 1 each: active-low SRAM controls.
- `SRAM_A` output ADDR_W: SRAM address.
- `SRAM_D` inout DATA_W: SRAM data; driven only during write states, otherwise high-Z.

## Operation
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD. All pin outputs are registered.
- IDLE: `req_ready`=1; all controls high; `SRAM_D` high-Z; `SRAM_A` holds its last value.
- Read accept (edge E0) -> RD: `SRAM_A`=addr, `SRAM_CE`=`SRAM_OE`=`SRAM_LB`=`SRAM_UB`=0. A down-counter is loaded with `READ_LATENCY`. At edge E0+READ_LATENCY+1: latch `SRAM_D` into `rsp_rdata`, set `rsp_valid`=1 for one cycle, deassert all controls, return to IDLE.
- Write accept (E0) -> WR_SETUP: `SRAM_A`/`SRAM_D` driven, `SRAM_CE`=0, LB/UB = ~`req_be`, `SRAM_WE`=1.
  - -> WR_PULSE (E1): `SRAM_WE`=0.
  - -> WR_HOLD (E2): `SRAM_WE`=1, address and data still driven.
  - -> IDLE (E3): controls high, `SRAM_D` released.
- `req_be`=00 write: full sequence runs with LB=UB=1. No byte is written; this is not an error.
- Request fields are captured at accept. Input changes after accept are ignored.
- `SRAM_OE` is never low while `SRAM_D` is driven.

## Timing
- Reset (async assert, released synchronously by design use): state IDLE, `SRAM_CE`/`OE`/`WE`/`LB`/`UB`=1, `SRAM_A`=0, `SRAM_D` high-Z, `rsp_valid`=0, `rsp_rdata`=0, `req_ready`=1.
- Reset mid-operation: the sequence aborts immediately. No `rsp_valid` is issued and no further write pulse occurs.
- Read occupancy is READ_LATENCY+1 cycles; `req_ready` returns high in the cycle after the response edge. With the default, the read issue-to-issue interval is 4 cycles.
- Write occupancy is 3 cycles; issue-to-issue interval is 4 cycles.
- `req_ready` is combinational from state (IDLE only). No accept occurs in the same cycle as `rsp_valid`.

## Structure
- `sram_pkg`: state enum, the `READ_LATENCY` default, and the control-inactive constant (5'b11111).
- Sub-module `sram_dq_buf`: tri-state data pad taking `oe`, `dout`, returning `din`. It isolates the inout from the FSM.
- Remainder: one FSM plus latency counter in `sram_ctrl`.

## Test plan
- Reset: hold `rst_n`=0 mid-simulation -> all controls 1, `SRAM_A`=0, `SRAM_D`=Z, `req_ready`=1.
- Read with a 2-cycle-latency SRAM model preloaded with data[0x005]=0xBEEF: read 0x005 -> `rsp_valid` pulse at E0+3, `rsp_rdata`=0xBEEF, `SRAM_OE`/`SRAM_CE` low for exactly 3 cycles.
- Write then read with a writable model: write 0x1A5=0x1234, be=11, then read 0x1A5 -> 0x1234. Verify one `SRAM_WE` low cycle with address/data stable one cycle either side.
- Byte writes: preload 0xAAAA, write 0x5555 with be=01 -> read 0xAA55; be=10 -> 0x55AA; be=00 -> unchanged.
- Back-to-back: `req_valid` held high with 3 queued reads -> accepts spaced 4 cycles apart, responses in order. `SRAM_D` is never driven by both sides, checked for X on the bus.
- Reset asserted in WR_PULSE -> `SRAM_WE` rises asynchronously, no `rsp_valid`, and the next read returns the old data or the new data depending on model write semantics, never X.
